spi_dac_tx: RTL and testbench

Serialises the 8-bit trigger reference level from the rotary-encoder decoder into 16-bit SPI frames for an MCP4901-class 8-bit DAC. The block runs on the system clock and resynchronises the level, which is produced in the encoder's own edge domain. It sends a frame only when the settled level changes, on a refresh request, or once after reset. It sits between the encoder decoder and the DAC pins.

---
 rtl/spi_dac_tx_if.sv | 26 ++
 rtl/spi_dac_tx.sv | 157 +++++++++++++++
 tb/tb_spi_dac_tx.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_dac_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_dac_tx_if
// Purpose  : Level/refresh inputs and DAC pin/status outputs of spi_dac_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_dac_tx_if;
  logic [7:0] level_in;
  logic       refresh;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       busy;
  logic       done;

  modport master (
    input  level_in, refresh,
    output sclk, mosi, cs_n, busy, done
  );

  modport slave (
    output level_in, refresh,
    input  sclk, mosi, cs_n, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/spi_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_dac_tx
// Purpose  : Resynchronises the encoder reference level and sends it to an
//            MCP4901-class DAC as 16-bit SPI mode-0 frames on change/refresh.
// Revision : 1.0 - initial release
// ============================================================================
module spi_dac_tx #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [3:0]  CFG_BITS = 4'b0011
) (
  input wire           clk,
  input wire           reset_n,
  spi_dac_tx_if.master bus
);

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic [7:0]  r_cmp;
  logic [7:0]  r_settled;
  logic [7:0]  r_sent;
  logic        r_pend_init;
  logic        r_refresh_pend;
  state_t      r_state;
  logic [15:0] r_shift;
  logic [7:0]  r_phase;
  logic [3:0]  r_bit;
  logic        r_high;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_cs_n;
  logic        r_busy;
  logic        r_done;

  logic        w_launch;
  logic [15:0] w_frame;

  // Left out of reset so the level seen just before a reset is still the
  // settled value sent by the power-up frame after release.
  always_ff @(posedge clk) begin
    r_sync1 <= bus.level_in;
    r_sync2 <= r_sync1;
    r_cmp   <= r_sync2;
    if (r_sync2 == r_cmp) begin
      r_settled <= r_sync2;
    end
  end

  assign w_launch = r_pend_init | r_refresh_pend | (r_settled != r_sent);
  assign w_frame  = {CFG_BITS, r_settled, 4'b0000};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_sent         <= 8'd0;
      r_pend_init    <= 1'b1;
      r_refresh_pend <= 1'b0;
      r_shift        <= 16'd0;
      r_phase        <= 8'd0;
      r_bit          <= 4'd0;
      r_high         <= 1'b0;
      r_sclk         <= 1'b0;
      r_mosi         <= 1'b0;
      r_cs_n         <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state        <= SHIFT;
            r_cs_n         <= 1'b0;
            r_busy         <= 1'b1;
            r_sclk         <= 1'b0;
            r_mosi         <= w_frame[15];
            r_shift        <= {w_frame[14:0], 1'b0};
            r_phase        <= c_div_last;
            r_bit          <= 4'd15;
            r_high         <= 1'b0;
            r_sent         <= r_settled;
            r_pend_init    <= 1'b0;
            r_refresh_pend <= 1'b0;
          end
        end
        SHIFT: begin
          if (r_phase != 8'd0) begin
            r_phase <= r_phase - 8'd1;
          end else begin
            r_phase <= c_div_last;
            if (!r_high) begin
              r_high <= 1'b1;
              r_sclk <= 1'b1;
            end else begin
              r_high <= 1'b0;
              r_sclk <= 1'b0;
              if (r_bit == 4'd0) begin
                r_state <= HOLD;
                r_mosi  <= 1'b0;
              end else begin
                r_bit   <= r_bit - 4'd1;
                r_mosi  <= r_shift[15];
                r_shift <= {r_shift[14:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (r_phase != 8'd0) begin
            r_phase <= r_phase - 8'd1;
          end else begin
            r_phase <= c_div_last;
            r_high  <= 1'b0;
            r_state <= GAP;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        GAP: begin
          // 2*CLK_DIV does not fit the phase counter, so count two halves.
          if (r_phase != 8'd0) begin
            r_phase <= r_phase - 8'd1;
          end else if (!r_high) begin
            r_high  <= 1'b1;
            r_phase <= c_div_last;
          end else begin
            r_high  <= 1'b0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A refresh in the launch cycle must survive the latch clear above.
      if (bus.refresh) begin
        r_refresh_pend <= 1'b1;
      end
    end
  end

  assign bus.sclk = r_sclk;
  assign bus.mosi = r_mosi;
  assign bus.cs_n = r_cs_n;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_dac_tx
// Purpose  : Self-checking bench for spi_dac_tx at CLK_DIV = 2, 1 and 255.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_dac_tx;

  logic       clk = 1'b0;
  logic       rstn_m, rstn_e, ref_m, ref_e;
  logic [7:0] lvl_m, lvl_e;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  always #5 clk = ~clk;

  spi_dac_tx_if bus0 ();
  spi_dac_tx_if bus1 ();
  spi_dac_tx_if bus2 ();

  assign bus0.level_in = lvl_m;
  assign bus0.refresh  = ref_m;
  assign bus1.level_in = lvl_e;
  assign bus1.refresh  = ref_e;
  assign bus2.level_in = lvl_e;
  assign bus2.refresh  = ref_e;

  spi_dac_tx #(.CLK_DIV(2))   u_dut0 (.clk(clk), .reset_n(rstn_m), .bus(bus0));
  spi_dac_tx #(.CLK_DIV(1))   u_dut1 (.clk(clk), .reset_n(rstn_e), .bus(bus1));
  spi_dac_tx #(.CLK_DIV(255)) u_dut2 (.clk(clk), .reset_n(rstn_e), .bus(bus2));

  // {sclk, mosi, cs_n, busy, done}
  logic [4:0] pin [3];
  assign pin[0] = {bus0.sclk, bus0.mosi, bus0.cs_n, bus0.busy, bus0.done};
  assign pin[1] = {bus1.sclk, bus1.mosi, bus1.cs_n, bus1.busy, bus1.done};
  assign pin[2] = {bus2.sclk, bus2.mosi, bus2.cs_n, bus2.busy, bus2.done};

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 255);
  endfunction
  function automatic logic rstn_of(input int i);
    return (i == 0) ? rstn_m : rstn_e;
  endfunction
  function automatic logic [7:0] lvl_of(input int i);
    return (i == 0) ? lvl_m : lvl_e;
  endfunction
  function automatic logic ref_of(input int i);
    return (i == 0) ? ref_m : ref_e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h (%0d), want 0x%0h (%0d)", nm, act, act, want, want);
    end
  endtask

  // Behavioural model: level history, frame decision, and pin values as a
  // function of the cycle offset t since launch.
  bit [7:0]  mh [3][4];
  bit [7:0]  m_settled [3];
  bit [7:0]  m_sent [3];
  bit        m_pend [3];
  bit        m_refl [3];
  bit        m_act [3];
  int        m_t [3];
  bit [15:0] m_frame [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 1'b1;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        for (int k = 3; k > 0; k--) mh[i][k] = mh[i][k-1];
        mh[i][0] = lvl_of(i);
        if (!rstn_of(i)) begin
          m_pend[i] = 1'b1;
          m_sent[i] = 8'd0;
          m_refl[i] = 1'b0;
          m_act[i]  = 1'b0;
          m_t[i]    = 0;
        end else begin
          if (m_act[i]) begin
            m_t[i]++;
            if (m_t[i] == 35 * div_of(i)) m_act[i] = 1'b0;
          end else if (m_pend[i] || m_refl[i] || (m_settled[i] != m_sent[i])) begin
            m_act[i]   = 1'b1;
            m_t[i]     = 0;
            m_frame[i] = {4'b0011, m_settled[i], 4'b0000};
            m_sent[i]  = m_settled[i];
            m_pend[i]  = 1'b0;
            m_refl[i]  = 1'b0;
          end
          if (ref_of(i)) m_refl[i] = 1'b1;
        end
        if (mh[i][2] == mh[i][3]) m_settled[i] = mh[i][2];
      end
    end
  end

  // Frame decoder records, as seen at the pins.
  bit        d_in [3];
  logic [4:0] d_prev [3];
  bit [15:0] d_sh [3];
  int        d_bits [3], d_cs [3], d_busy [3], d_hcnt [3], d_hmin [3], d_hmax [3], d_launch [3];
  bit [15:0] rec_data [3][32];
  int        rec_bits [3][32], rec_cs [3][32], rec_busy [3][32];
  int        rec_launch [3][32], rec_bfall [3][32], rec_hmin [3][32], rec_hmax [3][32];
  int        nf [3];

  initial begin
    logic [4:0] want;
    int t, d;
    for (int i = 0; i < 3; i++) d_prev[i] = 5'b00100;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (cyc > 0) begin
          want = 5'b00100;
          if (rstn_of(i) && m_act[i]) begin
            t = m_t[i];
            d = div_of(i);
            want[4] = (t < 32 * d) && (((t / d) % 2) == 1);
            want[3] = (t < 32 * d) ? m_frame[i][15 - t / (2 * d)] : 1'b0;
            want[2] = !(t < 33 * d);
            want[1] = 1'b1;
            want[0] = (t == 33 * d);
          end
          total++;
          if (pin[i] !== want) begin
            bad++;
            $display("FAIL pins_dut%0d cyc %0d: got %b, want %b", i, cyc, pin[i], want);
          end
        end
        if (!rstn_of(i)) begin
          d_in[i]   = 1'b0;
          d_prev[i] = 5'b00100;
        end else begin
          if (d_prev[i][2] && !pin[i][2]) begin
            d_in[i] = 1'b1; d_sh[i] = 16'd0; d_bits[i] = 0; d_cs[i] = 0; d_busy[i] = 0;
            d_hcnt[i] = 0; d_hmin[i] = 100000; d_hmax[i] = 0; d_launch[i] = cyc;
          end
          if (d_in[i]) begin
            if (!pin[i][2]) d_cs[i]++;
            if (pin[i][1]) d_busy[i]++;
            if (pin[i][4]) d_hcnt[i]++;
            if (pin[i][4] && !d_prev[i][4]) begin
              d_sh[i] = {d_sh[i][14:0], pin[i][3]};
              d_bits[i]++;
            end
            if (!pin[i][4] && d_prev[i][4]) begin
              if (d_hcnt[i] < d_hmin[i]) d_hmin[i] = d_hcnt[i];
              if (d_hcnt[i] > d_hmax[i]) d_hmax[i] = d_hcnt[i];
              d_hcnt[i] = 0;
            end
            if (!pin[i][1] && d_prev[i][1] && nf[i] < 32) begin
              rec_data[i][nf[i]]   = d_sh[i];
              rec_bits[i][nf[i]]   = d_bits[i];
              rec_cs[i][nf[i]]     = d_cs[i];
              rec_busy[i][nf[i]]   = d_busy[i];
              rec_launch[i][nf[i]] = d_launch[i];
              rec_bfall[i][nf[i]]  = cyc;
              rec_hmin[i][nf[i]]   = d_hmin[i];
              rec_hmax[i][nf[i]]   = d_hmax[i];
              nf[i]++;
              d_in[i] = 1'b0;
            end
          end
          d_prev[i] = pin[i];
        end
      end
    end
  end

  task automatic wait_nf(input int i, input int n, input int lim, input string nm);
    int k = 0;
    while (nf[i] < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_frames"}, nf[i], n);
  endtask

  task automatic wait_cs_low(input int lim, input string nm);
    int k = 0;
    while (pin[0][2] !== 1'b0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_cs_low"}, pin[0][2], 0);
  endtask

  task automatic main_seq();
    int n, k;
    @(negedge clk);
    rstn_m = 1'b1;
    wait_nf(0, 1, 400, "pwr");
    chk("pwr_data",   rec_data[0][0], 16'h3000);
    chk("pwr_cs_low", rec_cs[0][0], 66);
    chk("pwr_busy",   rec_busy[0][0], 70);
    chk("pwr_bits",   rec_bits[0][0], 16);
    repeat (200) @(negedge clk);
    chk("pwr_quiet",  nf[0], 1);

    lvl_m = 8'hA5;
    n = cyc + 1;
    wait_nf(0, 2, 400, "chg");
    chk("chg_latency", rec_launch[0][1] - n, 4);
    chk("chg_data",    rec_data[0][1], 16'h3A50);
    chk("chg_hi_min",  rec_hmin[0][1], 2);
    chk("chg_hi_max",  rec_hmax[0][1], 2);

    @(negedge clk);
    lvl_m = 8'h01;
    wait_cs_low(50, "burst");
    repeat (8) @(negedge clk);
    lvl_m = 8'h02;
    repeat (6) @(negedge clk);
    lvl_m = 8'h03;
    repeat (6) @(negedge clk);
    lvl_m = 8'h04;
    wait_nf(0, 4, 400, "burst");
    chk("burst_first",  rec_data[0][2], 16'h3010);
    chk("burst_follow", rec_data[0][3], 16'h3040);
    chk("burst_gap",    rec_launch[0][3] - rec_bfall[0][2], 1);
    repeat (200) @(negedge clk);
    chk("burst_quiet",  nf[0], 4);

    lvl_m = 8'h7F;
    wait_nf(0, 5, 400, "lvl7f");
    chk("lvl7f_data", rec_data[0][4], 16'h37F0);
    repeat (20) @(negedge clk);
    ref_m = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    ref_m = 1'b0;
    wait_cs_low(50, "ref");
    repeat (20) @(negedge clk);
    ref_m = 1'b1;
    @(negedge clk);
    ref_m = 1'b0;
    wait_nf(0, 7, 400, "ref");
    chk("ref_latency", rec_launch[0][5] - n, 1);
    chk("ref_data1",   rec_data[0][5], 16'h37F0);
    chk("ref_data2",   rec_data[0][6], 16'h37F0);
    chk("ref_gap",     rec_launch[0][6] - rec_bfall[0][5], 1);
    repeat (200) @(negedge clk);
    chk("ref_quiet",   nf[0], 7);

    lvl_m = 8'h5A;
    wait_cs_low(50, "rst");
    k = 0;
    while (d_bits[0] < 6 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_at_bit9", d_bits[0], 6);
    @(posedge clk);
    #1;
    rstn_m = 1'b0;
    #1;
    chk("rst_cs_n", bus0.cs_n, 1);
    chk("rst_sclk", bus0.sclk, 0);
    chk("rst_mosi", bus0.mosi, 0);
    chk("rst_busy", bus0.busy, 0);
    repeat (4) @(negedge clk);
    rstn_m = 1'b1;
    wait_nf(0, 8, 400, "rst");
    chk("rst_data",  rec_data[0][7], 16'h35A0);
    chk("rst_bits",  rec_bits[0][7], 16);
    repeat (100) @(negedge clk);
    chk("rst_quiet", nf[0], 8);
  endtask

  task automatic ext_seq();
    @(negedge clk);
    rstn_e = 1'b1;
    wait_nf(1, 1, 200, "div1_pwr");
    wait_nf(2, 1, 10000, "div255_pwr");
    chk("div1_data",     rec_data[1][0], 16'h3000);
    chk("div1_cs_low",   rec_cs[1][0], 33);
    chk("div1_busy",     rec_busy[1][0], 35);
    chk("div255_data",   rec_data[2][0], 16'h3000);
    chk("div255_cs_low", rec_cs[2][0], 8415);
    chk("div255_busy",   rec_busy[2][0], 8925);
    lvl_e = 8'hC3;
    wait_nf(1, 2, 200, "div1_chg");
    wait_nf(2, 2, 10000, "div255_chg");
    chk("div1_chg_data",   rec_data[1][1], 16'h3C30);
    chk("div1_hi",         rec_hmax[1][1], 1);
    chk("div255_chg_data", rec_data[2][1], 16'h3C30);
    chk("div255_hi",       rec_hmin[2][1], 255);
  endtask

  initial begin
    rstn_m = 1'b0;
    rstn_e = 1'b0;
    lvl_m  = 8'h00;
    lvl_e  = 8'h00;
    ref_m  = 1'b0;
    ref_e  = 1'b0;
    repeat (6) @(negedge clk);
    chk("reset_pins0", pin[0], 5'b00100);
    chk("reset_pins1", pin[1], 5'b00100);
    chk("reset_pins2", pin[2], 5'b00100);
    fork
      main_seq();
      ext_seq();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
